// File: rtl/bp_l15_pkg.sv
// Shared types and helpers for the L1.5 return path: return-type codes, the request
// context record, and the load-data extraction function.
package bp_l15_pkg;

  localparam logic [3:0] L15_LOAD_RET = 4'b0000;
  localparam logic [3:0] L15_ST_ACK   = 4'b0100;
  localparam logic [3:0] L15_INV_RET  = 4'b0011;
  localparam logic [3:0] L15_INT_RET  = 4'b0111;

  localparam int L15_PADDR_W = 40;

  typedef struct packed {
    logic [L15_PADDR_W-1:0] addr;
    logic [1:0]             size;
    logic                   store;
  } bp_l15_ctx_s;

  localparam int L15_CTX_W = $bits(bp_l15_ctx_s);

  typedef enum logic {ST_IDLE, ST_RESP} bp_l15_state_e;

  // The L1.5 hands back 16B big-endian; BP wants the addressed bytes little-endian at bit 0.
  function automatic logic [63:0] l15_extract_data(input logic [63:0] d0,
                                                   input logic [63:0] d1,
                                                   input logic [3:0]  addr,
                                                   input logic [1:0]  size);
    logic [63:0] be, le, sh, mask;
    be = addr[3] ? d1 : d0;
    for (int i = 0; i < 8; i++) le[8*i +: 8] = be[56-8*i +: 8];
    sh = le >> {addr[2:0], 3'b000};
    case (size)
      2'd0:    mask = 64'h0000_0000_0000_00FF;
      2'd1:    mask = 64'h0000_0000_0000_FFFF;
      2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return sh & mask;
  endfunction

  function automatic logic l15_misaligned(input logic [2:0] addr, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr[0];
      2'd2:    return |addr[1:0];
      default: return |addr[2:0];
    endcase
  endfunction

endpackage

// File: rtl/bp_l15_ctx_fifo.sv
// In-order FIFO of outstanding request contexts. Depth must be a power of 2 so the
// pointers wrap for free; a pop frees a slot for a same-cycle push when full.
module bp_l15_ctx_fifo
  import bp_l15_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 push_i,
  input  logic [L15_CTX_W-1:0] data_i,
  input  logic                 pop_i,
  output logic [L15_CTX_W-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = $clog2(els_p);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(els_p);

  logic [L15_CTX_W-1:0] r_mem [els_p];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 w_push, w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_l15_return_buffer.sv
// Acks L1.5 returns, pairs them in order with issued request contexts, and presents one
// little-endian, zero-extended valid/ready response per request to BP.
module bp_l15_return_buffer
  import bp_l15_pkg::*;
#(
  parameter int paddr_width_p = L15_PADDR_W,
  parameter int ctx_els_p     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     ctx_v_i,
  input  logic [paddr_width_p-1:0] ctx_addr_i,
  input  logic [1:0]               ctx_size_i,
  input  logic                     ctx_store_i,
  output logic                     ctx_ready_o,
  input  logic                     l15_transducer_val,
  input  logic [3:0]               l15_transducer_returntype,
  input  logic [63:0]              l15_transducer_data_0,
  input  logic [63:0]              l15_transducer_data_1,
  output logic                     transducer_l15_req_ack,
  output logic                     resp_v_o,
  output logic                     resp_store_o,
  output logic [paddr_width_p-1:0] resp_addr_o,
  output logic [63:0]              resp_data_o,
  input  logic                     resp_ready_i,
  output logic                     err_o
);

  bp_l15_state_e r_state, w_state_n;
  bp_l15_ctx_s   w_ctx_in, w_head;
  logic [L15_CTX_W-1:0] w_head_raw;

  logic w_full, w_empty, w_push, w_pop;
  logic w_ack, w_err_set, w_load_resp;
  logic w_is_mem_ret, w_is_unsol;

  logic                     r_err;
  logic                     r_resp_store;
  logic [paddr_width_p-1:0] r_resp_addr;
  logic [63:0]              r_resp_data;

  assign w_ctx_in.addr  = L15_PADDR_W'(ctx_addr_i);
  assign w_ctx_in.size  = ctx_size_i;
  assign w_ctx_in.store = ctx_store_i;
  assign w_head         = bp_l15_ctx_s'(w_head_raw);

  assign ctx_ready_o = ~w_full;
  assign w_push      = ctx_v_i & ctx_ready_o;

  bp_l15_ctx_fifo #(.els_p(ctx_els_p)) u_ctx_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (w_push),
    .data_i    (w_ctx_in),
    .pop_i     (w_pop),
    .head_o    (w_head_raw),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign w_is_mem_ret = (l15_transducer_returntype == L15_LOAD_RET) ||
                        (l15_transducer_returntype == L15_ST_ACK);
  assign w_is_unsol   = (l15_transducer_returntype == L15_INV_RET) ||
                        (l15_transducer_returntype == L15_INT_RET);

  // Every return seen in IDLE is acked; only a type-matched one with a context becomes a response.
  always_comb begin
    w_state_n   = r_state;
    w_ack       = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    w_load_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (l15_transducer_val) begin
          w_ack = 1'b1;
          if (w_is_mem_ret) begin
            if (w_empty) begin
              w_err_set = 1'b1;
            end else begin
              w_pop = 1'b1;
              if (w_head.store != (l15_transducer_returntype == L15_ST_ACK)) begin
                w_err_set = 1'b1;
              end else begin
                w_load_resp = 1'b1;
                w_state_n   = ST_RESP;
                if (!w_head.store && l15_misaligned(w_head.addr[2:0], w_head.size))
                  w_err_set = 1'b1;
              end
            end
          end else if (!w_is_unsol) begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready_i) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_IDLE;
      r_err        <= 1'b0;
      r_resp_store <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_err_set) r_err <= 1'b1;
      if (w_load_resp) begin
        r_resp_store <= w_head.store;
        r_resp_addr  <= paddr_width_p'(w_head.addr);
        r_resp_data  <= w_head.store ? 64'd0 :
                        l15_extract_data(l15_transducer_data_0, l15_transducer_data_1,
                                         w_head.addr[3:0], w_head.size);
      end
    end
  end

  assign transducer_l15_req_ack = w_ack;
  assign resp_v_o               = (r_state == ST_RESP);
  assign resp_store_o           = r_resp_store;
  assign resp_addr_o            = r_resp_addr;
  assign resp_data_o            = r_resp_data;
  assign err_o                  = r_err;

endmodule

// File: tb/tb_bp_l15_return_buffer.sv
// Directed bench for bp_l15_return_buffer: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every response handshake.
module tb_bp_l15_return_buffer;

  localparam int AW = 40;
  localparam logic [3:0] RT_LD = 4'b0000, RT_ST = 4'b0100, RT_INV = 4'b0011, RT_INT = 4'b0111;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          ctx_v_i;
  logic [AW-1:0] ctx_addr_i;
  logic [1:0]    ctx_size_i;
  logic          ctx_store_i;
  logic          ctx_ready_o;
  logic          l15_val;
  logic [3:0]    l15_rt;
  logic [63:0]   l15_d0, l15_d1;
  logic          req_ack;
  logic          resp_v_o, resp_store_o;
  logic [AW-1:0] resp_addr_o;
  logic [63:0]   resp_data_o;
  logic          resp_ready_i;
  logic          err_o;

  typedef struct {
    logic          store;
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  int   exp_ack = 0;

  always #5 clk_i = ~clk_i;

  bp_l15_return_buffer #(.paddr_width_p(AW), .ctx_els_p(4)) dut (
    .clk_i                     (clk_i),
    .reset_n_i                 (reset_n_i),
    .ctx_v_i                   (ctx_v_i),
    .ctx_addr_i                (ctx_addr_i),
    .ctx_size_i                (ctx_size_i),
    .ctx_store_i               (ctx_store_i),
    .ctx_ready_o               (ctx_ready_o),
    .l15_transducer_val        (l15_val),
    .l15_transducer_returntype (l15_rt),
    .l15_transducer_data_0     (l15_d0),
    .l15_transducer_data_1     (l15_d1),
    .transducer_l15_req_ack    (req_ack),
    .resp_v_o                  (resp_v_o),
    .resp_store_o              (resp_store_o),
    .resp_addr_o               (resp_addr_o),
    .resp_data_o               (resp_data_o),
    .resp_ready_i              (resp_ready_i),
    .err_o                     (err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: acks are counted, every response handshake is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (req_ack) ack_cnt++;
      if (resp_v_o && resp_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got addr 0x%0h data 0x%0h, none expected",
                   resp_addr_o, resp_data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (resp_store_o !== e.store || resp_addr_o !== e.addr || resp_data_o !== e.data) begin
            errors++;
            $display("FAIL resp: got st=%0b addr=0x%0h data=0x%0h expected st=%0b addr=0x%0h data=0x%0h",
                     resp_store_o, resp_addr_o, resp_data_o, e.store, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic push_ctx(input logic [AW-1:0] a, input logic [1:0] sz, input logic st);
    ctx_v_i = 1'b1; ctx_addr_i = a; ctx_size_i = sz; ctx_store_i = st;
    tick();
    ctx_v_i = 1'b0;
  endtask

  task automatic expect_resp(input logic st, input logic [AW-1:0] a, input logic [63:0] d);
    exp_t e;
    e.store = st; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Hold val until the DUT acks; waits counts cycles spent before the ack.
  task automatic send_ret(input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1,
                          output int waits);
    bit got = 0;
    waits = 0;
    l15_val = 1'b1; l15_rt = rt; l15_d0 = d0; l15_d1 = d1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_i);
      if (req_ack) got = 1; else waits++;
      tick();
    end
    l15_val = 1'b0;
    exp_ack++;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 50 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset_n_i = 1'b0; ctx_v_i = 1'b0; ctx_addr_i = '0; ctx_size_i = '0; ctx_store_i = 1'b0;
    l15_val = 1'b0; l15_rt = '0; l15_d0 = '0; l15_d1 = '0; resp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ack", req_ack, 0);
    tick();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ctx_ready", ctx_ready_o, 1);
    tick();

    // 8B load, aligned
    push_ctx(40'h80, 2'd3, 1'b0);
    expect_resp(1'b0, 40'h80, 64'h7766554433221100);
    send_ret(RT_LD, 64'h0011223344556677, 64'h0, w);
    chk("t1_ack_same_cycle", w, 0);
    @(negedge clk_i);
    chk("t1_resp_latency", resp_v_o, 1);
    tick();

    // 1B load from the upper half
    push_ctx(40'h8B, 2'd0, 1'b0);
    expect_resp(1'b0, 40'h8B, 64'h33);
    send_ret(RT_LD, 64'h0, 64'h0011223344556677, w);
    repeat (2) tick();

    // Four outstanding, first response back-pressured
    push_ctx(40'h100, 2'd3, 1'b0);
    push_ctx(40'h208, 2'd3, 1'b1);
    push_ctx(40'h310, 2'd2, 1'b0);
    push_ctx(40'h418, 2'd3, 1'b1);
    @(negedge clk_i);
    chk("t3_ctx_full", ctx_ready_o, 0);
    tick();
    expect_resp(1'b0, 40'h100, 64'h0807060504030201);
    expect_resp(1'b1, 40'h208, 64'h0);
    expect_resp(1'b0, 40'h310, 64'hDDCCBBAA);
    expect_resp(1'b1, 40'h418, 64'h0);
    resp_ready_i = 1'b0;
    fork
      begin repeat (4) @(posedge clk_i); #1 resp_ready_i = 1'b1; end
    join_none
    send_ret(RT_LD, 64'h0102030405060708, 64'h0, w);
    send_ret(RT_ST, 64'h0, 64'h0, w);
    chk("t3_st_stalled_in_resp", (w > 2) ? 64'd1 : 64'd0, 1);
    send_ret(RT_LD, 64'hAABBCCDD11223344, 64'h0, w);
    send_ret(RT_ST, 64'h0, 64'h0, w);
    repeat (3) tick();
    chk("t3_ack_count", ack_cnt, exp_ack);
    chk("t3_ctx_ready", ctx_ready_o, 1);

    // Unsolicited returns are dropped without touching the FIFO
    push_ctx(40'h40, 2'd3, 1'b0);
    send_ret(RT_INT, 64'hDEAD, 64'hBEEF, w);
    send_ret(RT_INV, 64'hDEAD, 64'hBEEF, w);
    @(negedge clk_i);
    chk("t4_fifo_count", dut.u_ctx_fifo.r_count, 1);
    chk("t4_no_resp", resp_v_o, 0);
    tick();
    expect_resp(1'b0, 40'h40, 64'h1122334455667788);
    send_ret(RT_LD, 64'h8877665544332211, 64'h0, w);
    repeat (2) tick();
    chk("t4_err_clear", err_o, 0);
    chk("t4_ack_count", ack_cnt, exp_ack);

    // Store ack with nothing outstanding
    send_ret(RT_ST, 64'h0, 64'h0, w);
    chk("t5_ack_same_cycle", w, 0);
    @(negedge clk_i);
    chk("t5_no_resp", resp_v_o, 0);
    chk("t5_err_set", err_o, 1);
    repeat (3) tick();
    chk("t5_err_sticky", err_o, 1);

    // Reset while holding a response with two contexts queued
    push_ctx(40'h500, 2'd3, 1'b0);
    push_ctx(40'h508, 2'd3, 1'b0);
    push_ctx(40'h510, 2'd3, 1'b0);
    resp_ready_i = 1'b0;
    send_ret(RT_LD, 64'h1, 64'h2, w);
    @(negedge clk_i);
    chk("t6_resp_held", resp_v_o, 1);
    tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("t6_resp_dropped", resp_v_o, 0);
    chk("t6_fifo_empty", dut.u_ctx_fifo.r_count, 0);
    chk("t6_ctx_ready", ctx_ready_o, 1);
    chk("t6_err_cleared", err_o, 0);
    tick();
    resp_ready_i = 1'b1;

    // Misaligned 2B load still returns shifted data but flags an error
    push_ctx(40'h81, 2'd1, 1'b0);
    expect_resp(1'b0, 40'h81, 64'h2211);
    send_ret(RT_LD, 64'h0011223344556677, 64'h0, w);
    @(negedge clk_i);
    chk("t7_misaligned_err", err_o, 1);
    repeat (2) tick();

    // Load return against a store context: popped, no response
    push_ctx(40'h90, 2'd3, 1'b1);
    send_ret(RT_LD, 64'h55, 64'h66, w);
    @(negedge clk_i);
    chk("t8_no_resp", resp_v_o, 0);
    chk("t8_popped", dut.u_ctx_fifo.r_count, 0);
    repeat (3) tick();

    chk("end_scoreboard_empty", exp_q.size(), 0);
    chk("end_ack_count", ack_cnt, exp_ack);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
